// File: rtl/pwm_setpoint_ramp.sv
// Slew-rate limiter feeding the PWM modulator setpoint.
// Moves toward an accepted target by at most STEP every TICKS_PER_STEP periods.
module pwm_setpoint_ramp #(
    parameter int MOD_WIDTH      = 8,
    parameter int STEP           = 1,
    parameter int TICKS_PER_STEP = 1,
    parameter int RESET_VALUE    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [MOD_WIDTH-1:0] target,
    input  logic                 target_valid,
    output logic                 target_ready,
    input  logic                 period_tick,
    output logic [MOD_WIDTH-1:0] mod_setpoint,
    output logic                 busy,
    output logic                 done
);

    localparam int PW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam logic [PW-1:0]        LAST   = PW'(TICKS_PER_STEP - 1);
    localparam logic [MOD_WIDTH:0]   STEP_W = (MOD_WIDTH+1)'(STEP);
    localparam logic [MOD_WIDTH-1:0] RST_W  = MOD_WIDTH'(RESET_VALUE);

    typedef enum logic {S_IDLE, S_RAMP} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [MOD_WIDTH-1:0] r_setpoint;
    logic [MOD_WIDTH-1:0] r_target;
    logic [MOD_WIDTH-1:0] w_next_sp;
    logic [PW-1:0]        r_presc;
    logic                 r_tick_d;
    logic                 r_done;
    logic                 w_rise;
    logic                 w_accept;
    logic                 w_step;
    logic                 w_up;
    logic                 w_ready;
    logic                 w_busy;
    logic [MOD_WIDTH:0]   w_diff;
    logic [MOD_WIDTH:0]   w_delta;

    assign w_rise   = period_tick & ~r_tick_d;
    assign w_accept = target_valid & w_ready;
    assign w_step   = w_busy & w_rise & (r_presc == LAST);

    // Extra bit keeps the difference and the move free of wrap-around.
    assign w_up    = r_target > r_setpoint;
    assign w_diff  = w_up ? ({1'b0, r_target} - {1'b0, r_setpoint})
                          : ({1'b0, r_setpoint} - {1'b0, r_target});
    assign w_delta = (w_diff > STEP_W) ? STEP_W : w_diff;
    assign w_next_sp = MOD_WIDTH'(w_up ? ({1'b0, r_setpoint} + w_delta)
                                       : ({1'b0, r_setpoint} - w_delta));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (target_valid && (target != r_setpoint)) begin
                    w_state_next = S_RAMP;
                end
            end
            S_RAMP: begin
                if (w_step && (w_next_sp == r_target)) begin
                    w_state_next = S_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        w_ready = 1'b0;
        w_busy  = 1'b0;
        unique case (r_state)
            S_IDLE: w_ready = 1'b1;
            S_RAMP: w_busy  = 1'b1;
        endcase
    end

    // A tick seen in the accept cycle only clears the prescaler.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_setpoint <= RST_W;
            r_target   <= RST_W;
            r_presc    <= '0;
            r_tick_d   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_tick_d <= period_tick;
            r_done   <= 1'b0;
            if (w_accept) begin
                r_target <= target;
                r_presc  <= '0;
                if (target == r_setpoint) begin
                    r_done <= 1'b1;
                end
            end else if (w_busy && w_rise) begin
                if (r_presc == LAST) begin
                    r_presc    <= '0;
                    r_setpoint <= w_next_sp;
                    if (w_next_sp == r_target) begin
                        r_done <= 1'b1;
                    end
                end else begin
                    r_presc <= r_presc + PW'(1);
                end
            end
        end
    end

    assign target_ready = w_ready;
    assign busy         = w_busy;
    assign done         = r_done;
    assign mod_setpoint = r_setpoint;

endmodule

// File: tb/tb_pwm_setpoint_ramp.sv
// Bench for pwm_setpoint_ramp: four parameterisations against a
// behavioural model, directed scenarios followed by random traffic.
module tb_pwm_setpoint_ramp;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pt  = 1'b0;
    logic [7:0] tg  [N];
    logic       tv  [N];
    logic [7:0] sp  [N];
    logic       rdy [N];
    logic       bsy [N];
    logic       dn  [N];

    int total = 0;
    int bad   = 0;
    int dcnt  = 0;

    int m_sp   [N];
    int m_tg   [N];
    int m_cnt  [N];
    bit m_ramp [N];
    bit m_done [N];
    bit m_tickd;

    always #5 clk = ~clk;

    pwm_setpoint_ramp #(.MOD_WIDTH(8), .STEP(1), .TICKS_PER_STEP(1), .RESET_VALUE(0)) u_a (
        .clk(clk), .rst(rst), .target(tg[0]), .target_valid(tv[0]),
        .target_ready(rdy[0]), .period_tick(pt), .mod_setpoint(sp[0]),
        .busy(bsy[0]), .done(dn[0]));

    pwm_setpoint_ramp #(.MOD_WIDTH(8), .STEP(100), .TICKS_PER_STEP(1), .RESET_VALUE(0)) u_b (
        .clk(clk), .rst(rst), .target(tg[1]), .target_valid(tv[1]),
        .target_ready(rdy[1]), .period_tick(pt), .mod_setpoint(sp[1]),
        .busy(bsy[1]), .done(dn[1]));

    pwm_setpoint_ramp #(.MOD_WIDTH(8), .STEP(1), .TICKS_PER_STEP(3), .RESET_VALUE(0)) u_c (
        .clk(clk), .rst(rst), .target(tg[2]), .target_valid(tv[2]),
        .target_ready(rdy[2]), .period_tick(pt), .mod_setpoint(sp[2]),
        .busy(bsy[2]), .done(dn[2]));

    pwm_setpoint_ramp #(.MOD_WIDTH(8), .STEP(7), .TICKS_PER_STEP(2), .RESET_VALUE(0)) u_d (
        .clk(clk), .rst(rst), .target(tg[3]), .target_valid(tv[3]),
        .target_ready(rdy[3]), .period_tick(pt), .mod_setpoint(sp[3]),
        .busy(bsy[3]), .done(dn[3]));

    function automatic int stp(int i);
        case (i)
            1:       return 100;
            3:       return 7;
            default: return 1;
        endcase
    endfunction

    function automatic int tps(int i);
        case (i)
            2:       return 3;
            3:       return 2;
            default: return 1;
        endcase
    endfunction

    task automatic chk(string tag, logic [8:0] obs, logic [8:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_tickd = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_sp[i]   = 0;
            m_tg[i]   = 0;
            m_cnt[i]  = 0;
            m_ramp[i] = 1'b0;
            m_done[i] = 1'b0;
        end
    endtask

    // One clock of behaviour: accept, count strobe rises, step by min(STEP, distance).
    task automatic model_step();
        bit rise;
        int d;
        int mag;
        int s;
        if (rst) begin
            model_reset();
            return;
        end
        rise    = pt && !m_tickd;
        m_tickd = pt;
        for (int i = 0; i < N; i++) begin
            m_done[i] = 1'b0;
            if (!m_ramp[i]) begin
                if (tv[i]) begin
                    m_tg[i]  = int'(tg[i]);
                    m_cnt[i] = 0;
                    if (m_tg[i] == m_sp[i]) m_done[i] = 1'b1;
                    else m_ramp[i] = 1'b1;
                end
            end else if (rise) begin
                m_cnt[i]++;
                if (m_cnt[i] == tps(i)) begin
                    m_cnt[i] = 0;
                    d   = m_tg[i] - m_sp[i];
                    mag = (d < 0) ? -d : d;
                    s   = (mag < stp(i)) ? mag : stp(i);
                    m_sp[i] = m_sp[i] + ((d < 0) ? -s : s);
                    if (m_sp[i] == m_tg[i]) begin
                        m_ramp[i] = 1'b0;
                        m_done[i] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("sp%0d", i), {1'b0, sp[i]}, 9'(m_sp[i]));
            chk($sformatf("rdy%0d", i), {8'd0, rdy[i]}, {8'd0, !m_ramp[i]});
            chk($sformatf("busy%0d", i), {8'd0, bsy[i]}, {8'd0, m_ramp[i]});
            chk($sformatf("done%0d", i), {8'd0, dn[i]}, {8'd0, m_done[i]});
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check_all();
        if (dn[0] === 1'b1) dcnt++;
    endtask

    task automatic strobe(int hi, int lo);
        pt = 1'b1;
        repeat (hi) cyc();
        pt = 1'b0;
        repeat (lo) cyc();
    endtask

    int ea [7];
    int eb [7];
    int ec [7];

    initial begin
        ea = '{0, 1, 2, 3, 4, 5, 5};
        eb = '{0, 100, 200, 255, 155, 55, 0};
        ec = '{0, 0, 0, 1, 1, 1, 2};
        for (int i = 0; i < N; i++) begin
            tv[i] = 1'b0;
            tg[i] = 8'd0;
        end

        // Asynchronous reset, observed before any clock edge.
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("rst_sp", {1'b0, sp[0]}, 9'd0);
        chk("rst_ready", {8'd0, rdy[0]}, 9'd1);
        repeat (2) cyc();
        rst = 1'b0;
        cyc();

        // Accept coincides with a strobe rise; that rise must not count.
        tv[0] = 1'b1; tg[0] = 8'd5;
        tv[1] = 1'b1; tg[1] = 8'd255;
        tv[2] = 1'b1; tg[2] = 8'd2;
        pt = 1'b1;
        dcnt = 0;
        cyc();
        for (int i = 0; i < N; i++) tv[i] = 1'b0;
        chk("acc_busy", {8'd0, bsy[0]}, 9'd1);
        chk("acc_sp", {1'b0, sp[0]}, 9'd0);
        repeat (3) cyc();
        pt = 1'b0;
        repeat (4) cyc();

        for (int k = 1; k <= 6; k++) begin
            strobe(4, 4);
            chk($sformatf("up_a_%0d", k), {1'b0, sp[0]}, 9'(ea[k]));
            chk($sformatf("ramp_b_%0d", k), {1'b0, sp[1]}, 9'(eb[k]));
            chk($sformatf("presc_c_%0d", k), {1'b0, sp[2]}, 9'(ec[k]));
            if (k == 3) begin
                tv[1] = 1'b1; tg[1] = 8'd0;
                cyc();
                tv[1] = 1'b0;
            end
        end
        chk("a_done_count", 9'(dcnt), 9'd1);

        // Target equal to current: no ramp, done next cycle.
        tv[0] = 1'b1; tg[0] = 8'd5;
        cyc();
        tv[0] = 1'b0;
        chk("eq_busy", {8'd0, bsy[0]}, 9'd0);
        chk("eq_done", {8'd0, dn[0]}, 9'd1);
        cyc();
        chk("eq_done_clr", {8'd0, dn[0]}, 9'd0);

        // New target while ramping is ignored, even alongside a step.
        tv[0] = 1'b1; tg[0] = 8'd8;
        cyc();
        tg[0] = 8'd200;
        strobe(2, 2);
        tv[0] = 1'b0;
        repeat (3) strobe(2, 2);
        chk("ign_sp", {1'b0, sp[0]}, 9'd8);
        chk("ign_busy", {8'd0, bsy[0]}, 9'd0);

        // Reset mid-ramp abandons the ramp without done.
        rst = 1'b1;
        model_reset();
        cyc();
        rst = 1'b0;
        tv[0] = 1'b1; tg[0] = 8'd10;
        cyc();
        tv[0] = 1'b0;
        dcnt = 0;
        repeat (3) strobe(2, 2);
        chk("mid_sp3", {1'b0, sp[0]}, 9'd3);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_sp", {1'b0, sp[0]}, 9'd0);
        chk("mid_rst_done", {8'd0, dn[0]}, 9'd0);
        chk("mid_rst_busy", {8'd0, bsy[0]}, 9'd0);
        cyc();
        rst = 1'b0;
        chk("mid_no_done", 9'(dcnt), 9'd0);
        tv[0] = 1'b1; tg[0] = 8'd2;
        cyc();
        tv[0] = 1'b0;
        repeat (3) strobe(2, 2);
        chk("post_rst_sp", {1'b0, sp[0]}, 9'd2);
        chk("post_rst_done", 9'(dcnt), 9'd1);

        // Random traffic on all four instances.
        repeat (3000) begin
            for (int i = 0; i < N; i++) begin
                tv[i] = ($urandom_range(0, 7) == 0);
                tg[i] = 8'($urandom);
            end
            if ($urandom_range(0, 2) == 0) pt = ~pt;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_setpoint_ramp.md
# pwm_setpoint_ramp

Slew-rate limiter that sits directly upstream of the PWM modulator and drives its `mod_setpoint` input. It accepts a new target duty value over a valid/ready handshake, then moves the output toward that target by at most `STEP` counts once every `TICKS_PER_STEP` PWM periods. This keeps the ammeter needle from jumping. It signals completion with a one-cycle `done` pulse.

## Interface
- `MOD_WIDTH`, 8: setpoint bitness; must match the downstream modulator.
- `STEP`, 1: maximum change per step, 1..2^MOD_WIDTH-1.
- `TICKS_PER_STEP`, 1: PWM periods per step, ≥1.
- `RESET_VALUE`, 0: `mod_setpoint` value after reset.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-high reset.
- `target`  in  MOD_WIDTH: requested setpoint.
- `target_valid`  in  1: `target` is presented.
- `target_ready`  out  1: block can accept a target.
- `period_tick`  in  1: PWM period strobe, from the modulator's `start_strobe`; may be high for several `clk` cycles.
- `mod_setpoint`  out  MOD_WIDTH: registered setpoint to the modulator.
- `busy`  out  1: ramp in progress.
- `done`  out  1: one-cycle pulse when `mod_setpoint` reaches the accepted target.

## Operation
**Reset**
- Applies asynchronously.
- Values: `mod_setpoint`=RESET_VALUE, `target_ready`=1, `busy`=0, `done`=0, state IDLE, prescaler 0, `tick_d`=0, stored target=RESET_VALUE.
- A reset mid-ramp abandons the ramp immediately. No `done` pulse is produced.

**Tick detection**
- `tick_d` registers `period_tick`.
- `tick_rise` = `period_tick` & ~`tick_d`.
- Exactly one step event per strobe, regardless of strobe width.

**State IDLE**
- `target_ready`=1, `busy`=0.
- On `target_valid` & `target_ready`: store `target` and clear the prescaler.
- If `target` == `mod_setpoint`: stay in IDLE and assert `done` next cycle.
- Otherwise: go to RAMP.

**State RAMP**
- `target_ready`=0, `busy`=1. `target_valid` is ignored and the stored target is held.
- On each `tick_rise`, the prescaler increments.
- When the prescaler reaches TICKS_PER_STEP-1 together with a `tick_rise`, it wraps to 0 and a step occurs.

**Step arithmetic**
- Computed at MOD_WIDTH+1 bits.
- diff = |target − mod_setpoint|.
- delta = min(STEP, diff).
- `mod_setpoint` moves toward the target by delta. It never overshoots and never wraps past 0 or 2^MOD_WIDTH−1.
- When the step lands on the target: go to IDLE with `done`=1 for one cycle. `busy` drops in the same cycle.

## Timing
**Handshake**
- Transfer occurs on a rising `clk` edge with `target_valid` & `target_ready` high.
- `busy` rises on the next edge (1-cycle latency).
- `mod_setpoint` does not change on the accept edge.

**Step latency**
- `mod_setpoint` updates on the `clk` edge after the qualifying `tick_rise` cycle (1-cycle latency from the strobe's rising sample).

**Done**
- `done` is high in the same cycle that `mod_setpoint` first equals the target.
- `target_ready` returns to 1 in that same cycle, so a new target can be accepted in the cycle after `done`.

**Simultaneous events**
- A `tick_rise` in the accept cycle is consumed by clearing the prescaler. No step occurs on that tick.
- A step and `target_valid` in RAMP: the step proceeds and `target_valid` is ignored.

**Boundary conditions**
- Ramp 255→0 with STEP=100 produces 155, 55, 0. The last step uses delta=55.
- STEP ≥ diff finishes in one step.

**Step count**
- Total steps = ceil(diff/STEP).
- Ramp duration ≈ ceil(diff/STEP)·TICKS_PER_STEP PWM periods.

## Test plan
- Reset check: assert `rst` → `mod_setpoint`=0, `busy`=0, `done`=0, `target_ready`=1, all asynchronous (before the next `clk` edge).
- Up-ramp (STEP=1, TICKS_PER_STEP=1): target=5 from 0, with 6 strobes each 4 `clk` cycles wide → `mod_setpoint` reads 1,2,3,4,5, one step per strobe. `done` pulses once at 5. The 6th strobe causes no change.
- Clamped down-ramp (STEP=100): start at 255, target=0 → 155, 55, 0. Then `done`. No wrap.
- Prescaler (TICKS_PER_STEP=3, STEP=1): target=2 from 0 → setpoint changes on the 3rd and 6th strobes only. A strobe coincident with accept is not counted.
- Handshake: target=5 equal to current → no `busy`, `done` one cycle later. During RAMP, a `target_valid` pulse with target=200 → ignored, and the original target is reached.
- Reset mid-ramp: at `mod_setpoint`=3 of a 0→10 ramp, pulse `rst` → output 0 immediately, no `done`. A new target=2 is then accepted normally.
